// File: rtl/deser_pkg.sv
// Shared FSM state type, default sync pattern and a width helper for data_deserializer_align.
package deser_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hBC5A_3C5A;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/deser_bit_slip_ctr.sv
// Bit counter 0..W-1 producing the word boundary strobe; a slip holds the count for one extra bit.
module deser_bit_slip_ctr
  import deser_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic slip,
  output logic boundary
);

  localparam int unsigned BC_W = clog2(W);
  localparam logic [BC_W-1:0] LAST = BC_W'(W - 1);

  logic [BC_W-1:0] cnt;
  logic            hold;

  assign boundary = (cnt == LAST) && !hold;

  // A slip parks the counter on LAST for one non-boundary cycle, stretching that word to W+1 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      hold <= 1'b0;
    end else if (hold) begin
      cnt  <= '0;
      hold <= 1'b0;
    end else if (boundary) begin
      hold <= slip;
      if (!slip) cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/data_deserializer_align.sv
// Serial-to-parallel deserializer with sync-word bit-slip alignment.
// Optional DESER_LOSS_CNT_EN adds a saturating 16-bit lock-loss counter output.
module data_deserializer_align
  import deser_pkg::*;
#(
  parameter int unsigned  W         = 32,
  parameter logic [W-1:0] SYNC_WORD = W'(DEFAULT_SYNC_WORD),
  parameter int unsigned  FRAME_LEN = 8,
  parameter int unsigned  LOCK_CNT  = 4,
  parameter int unsigned  MISS_MAX  = 3
) (
  input  logic         clk1280,
  input  logic         rst_n,
  input  logic         rx,
  output logic [W-1:0] data_o,
  output logic         data_valid,
  output logic         sync_o,
  output logic         locked,
`ifdef DESER_LOSS_CNT_EN
  output logic [15:0]  loss_cnt_o,
`endif
  output logic         realign_o
);

  localparam int unsigned FP_W = clog2(FRAME_LEN);
  localparam int unsigned HC_W = clog2(LOCK_CNT + 1);
  localparam int unsigned MC_W = clog2(MISS_MAX + 1);
  localparam logic [FP_W-1:0] FP_LAST  = FP_W'(FRAME_LEN - 1);
  localparam logic [HC_W-1:0] LOCK_PRE = HC_W'(LOCK_CNT - 1);
  localparam logic [MC_W-1:0] MISS_PRE = MC_W'(MISS_MAX - 1);

  state_t          state, state_nx;
  logic            boundary, slip, emit, lose, match;
  logic [W-2:0]    sreg;
  logic [W-1:0]    word;
  logic [FP_W-1:0] fpos, fpos_nx, fpos_inc;
  logic [HC_W-1:0] hits, hits_nx;
  logic [MC_W-1:0] misses, misses_nx;

  deser_bit_slip_ctr #(.W(W)) u_ctr (
    .clk      (clk1280),
    .rst_n    (rst_n),
    .slip     (slip),
    .boundary (boundary)
  );

  // The oldest history bit is never read, so only W-1 bits are kept; rx supplies the newest.
  assign word     = {sreg, rx};
  assign match    = (word == SYNC_WORD);
  assign fpos_inc = (fpos == FP_LAST) ? '0 : fpos + 1'b1;

  always_comb begin
    state_nx  = state;
    fpos_nx   = fpos;
    hits_nx   = hits;
    misses_nx = misses;
    slip      = 1'b0;
    emit      = 1'b0;
    lose      = 1'b0;
    if (boundary) begin
      unique case (state)
        SEARCH: begin
          if (match) begin
            fpos_nx   = FP_W'(1);
            hits_nx   = HC_W'(1);
            misses_nx = '0;
            state_nx  = (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end else begin
            slip = 1'b1;
          end
        end
        VERIFY: begin
          fpos_nx = fpos_inc;
          if (fpos == '0) begin
            if (match) begin
              hits_nx = hits + 1'b1;
              if (hits == LOCK_PRE) begin
                state_nx  = LOCKED;
                misses_nx = '0;
              end
            end else begin
              state_nx = SEARCH;
              slip     = 1'b1;
              hits_nx  = '0;
            end
          end
        end
        LOCKED: begin
          emit    = 1'b1;
          fpos_nx = fpos_inc;
          if (fpos == '0) begin
            if (match) begin
              misses_nx = '0;
            end else if (misses == MISS_PRE) begin
              lose      = 1'b1;
              slip      = 1'b1;
              state_nx  = SEARCH;
              fpos_nx   = '0;
              hits_nx   = '0;
              misses_nx = '0;
            end else begin
              misses_nx = misses + 1'b1;
            end
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk1280) begin
    if (!rst_n) begin
      state      <= SEARCH;
      sreg       <= '0;
      fpos       <= '0;
      hits       <= '0;
      misses     <= '0;
      data_o     <= '0;
      data_valid <= 1'b0;
      sync_o     <= 1'b0;
      locked     <= 1'b0;
      realign_o  <= 1'b0;
    end else begin
      state      <= state_nx;
      sreg       <= word[W-2:0];
      fpos       <= fpos_nx;
      hits       <= hits_nx;
      misses     <= misses_nx;
      data_valid <= emit;
      sync_o     <= emit && (fpos == '0);
      realign_o  <= lose;
      if (emit) data_o <= word;
      // Updated only on boundaries so it rises together with the first data_valid.
      if (boundary) locked <= emit && !lose;
    end
  end

`ifdef DESER_LOSS_CNT_EN
  always_ff @(posedge clk1280) begin
    if (!rst_n) begin
      loss_cnt_o <= '0;
    end else if (lose && (loss_cnt_o != '1)) begin
      loss_cnt_o <= loss_cnt_o + 1'b1;
    end
  end
`endif

endmodule
